jive_pbus_master: RTL

Initiator for the JiVe peripheral bus. It accepts one access at a time from a core-side request port and drives the bus strobes, address, byte enables and write data. It waits for the responder's `dtack` and returns read data or an error on a one-cycle response port. It sits between the CPU load/store path and peripherals such as the machine timer, and it owns the bus turnaround and timeout rules.

---
 rtl/jive_pbus_pkg.sv | 29 ++
 rtl/jive_pbus_tmo.sv | 31 +++
 rtl/jive_pbus_master.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/jive_pbus_pkg.sv
// Shared types and constants for the JiVe peripheral bus.
// State encoding, bus widths and timer peripheral addresses.
package jive_pbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TURN   = 2'd2
  } state_t;

  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 2;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;

  typedef logic [ADDR_HI:ADDR_LO] waddr_t;
  typedef logic [DATA_W-1:0]      data_t;
  typedef logic [BE_W-1:0]        be_t;

  localparam logic [15:0] MTIMECMP_LO_A = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_A = 16'h4004;
  localparam logic [15:0] MTIME_LO_A    = 16'hC000;
  localparam logic [15:0] MTIME_HI_A    = 16'hC004;

  function automatic waddr_t word_of(input logic [15:0] a);
    return waddr_t'(a >> 2);
  endfunction

endpackage

// File: rtl/jive_pbus_tmo.sv
// Access timeout counter: cleared on accept, counts idle ACCESS cycles.
// Ports: clk, rst, clr, inc; expired is high once TMO_CYC-1 is reached.
module jive_pbus_tmo #(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt;

  assign expired = (cnt == LAST);

  // Holds at LAST so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jive_pbus_master.sv
// JiVe peripheral bus initiator: one access at a time, turnaround, timeout.
// Ports: req_* core request, resp_* completion pulse, csel/rden/wren/addr/
// bena/wdata/rdata/dtack bus side. Timeout present with JIVE_PBUS_TMO_EN.
module jive_pbus_master
  import jive_pbus_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic   rst,
  input  logic   clk,
  input  logic   req_vld,
  output logic   req_rdy,
  input  logic   req_we,
  input  waddr_t req_addr,
  input  be_t    req_be,
  input  data_t  req_wdata,
  output logic   resp_vld,
  output data_t  resp_rdata,
  output logic   resp_err,
  output logic   csel,
  output logic   rden,
  output logic   wren,
  output waddr_t addr,
  output be_t    bena,
  output data_t  wdata,
  input  data_t  rdata,
  input  logic   dtack
);

  state_t state_q;
  state_t state_d;

  logic  tmo_exp;
  logic  accept;
  logic  ack;
  logic  expire;
  logic  csel_d;
  logic  rden_d;
  logic  wren_d;
  logic  resp_vld_d;
  data_t rdata_d;

  assign req_rdy = (state_q == ST_IDLE);
  assign accept  = req_rdy && req_vld;
  assign ack     = (state_q == ST_ACCESS) && dtack;
  // dtack in the expiry cycle wins over the timeout.
  assign expire  = (state_q == ST_ACCESS) && !dtack && tmo_exp;

`ifdef JIVE_PBUS_TMO_EN
  jive_pbus_tmo #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .inc    ((state_q == ST_ACCESS) && !dtack),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else begin
      resp_err <= expire;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TMO_W > 0) ^ (TMO_CYC > 0);
  assign tmo_exp  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_vld) state_d = ST_ACCESS;
      ST_ACCESS: if (dtack || tmo_exp) state_d = ST_TURN;
      ST_TURN:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csel_d     = csel;
    rden_d     = rden;
    wren_d     = wren;
    resp_vld_d = 1'b0;
    rdata_d    = resp_rdata;
    unique case (1'b1)
      accept: begin
        csel_d = 1'b1;
        rden_d = !req_we;
        wren_d = req_we;
      end
      ack: begin
        csel_d     = 1'b0;
        rden_d     = 1'b0;
        wren_d     = 1'b0;
        resp_vld_d = 1'b1;
        rdata_d    = rden ? rdata : '0;
      end
      expire: begin
        csel_d     = 1'b0;
        rden_d     = 1'b0;
        wren_d     = 1'b0;
        resp_vld_d = 1'b1;
        rdata_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csel       <= 1'b0;
      rden       <= 1'b0;
      wren       <= 1'b0;
      addr       <= '0;
      bena       <= '0;
      wdata      <= '0;
      resp_vld   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      csel       <= csel_d;
      rden       <= rden_d;
      wren       <= wren_d;
      resp_vld   <= resp_vld_d;
      resp_rdata <= rdata_d;
      if (accept) begin
        addr  <= req_addr;
        bena  <= req_be;
        wdata <= req_wdata;
      end
    end
  end

endmodule
